// File: rtl/mem_wr_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_wr_arbiter.
// slave is the arbiter's view; master is the requesters plus memory register.
interface mem_wr_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 6
);
  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ack;
  logic                req_err;
  logic [DW-1:0]       mem_wdata;
  logic                mem_wrt_en;
  logic [DW-1:0]       mem_rdata;
  logic                busy;
  logic [IW-1:0]       last_grant;

  modport slave (
    input  req_valid, req_data, mem_rdata,
    output req_ack, req_err, mem_wdata, mem_wrt_en, busy, last_grant
  );

  modport master (
    output req_valid, req_data, mem_rdata,
    input  req_ack, req_err, mem_wdata, mem_wrt_en, busy, last_grant
  );
endinterface

// File: rtl/mem_wr_arbiter.sv
// Round-robin write arbiter for the shared memory register: grant, write one
// cycle, verify the readback, then ack the granted requester with an error flag.
module mem_wr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 6
) (
  input  logic               in_clk,
  input  logic               in_rst,
  mem_wr_arbiter_if.slave    bus
);
  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_gnt_idx;
  logic [IW-1:0]    r_last_grant;
  logic [DW-1:0]    r_wdata_q;

  logic             w_found;
  logic [IW-1:0]    w_sel_idx;
  logic [DW-1:0]    w_sel_data;
  logic [N_REQ-1:0] w_ack;
  logic             w_err;
  logic             w_wrt_en;
  logic             w_busy;

  // Round-robin search starting just above the last served requester.
  always_comb begin
    logic [IW:0] cand;
    cand      = '0;
    w_found   = 1'b0;
    w_sel_idx = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = {1'b0, r_ptr} + (IW+1)'(k);
      if (cand > (IW+1)'(N_REQ - 1)) begin
        cand = cand - (IW+1)'(N_REQ);
      end
      if (!w_found && bus.req_valid[cand[IW-1:0]]) begin
        w_found   = 1'b1;
        w_sel_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_data = bus.req_data[int'(w_sel_idx)*int'(DW) +: DW];
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ack        = '0;
    w_err        = 1'b0;
    w_wrt_en     = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_wrt_en     = 1'b1;
        w_busy       = 1'b1;
        w_next_state = ST_VERIFY;
      end
      ST_VERIFY: begin
        w_busy       = 1'b1;
        w_ack        = N_REQ'(1) << r_gnt_idx;
        w_err        = (bus.mem_rdata != r_wdata_q);
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Grant index and data are captured only when leaving IDLE.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_ptr        <= IW'(N_REQ - 1);
      r_gnt_idx    <= '0;
      r_wdata_q    <= '0;
      r_last_grant <= IW'(N_REQ - 1);
    end else begin
      if ((r_state == ST_IDLE) && w_found) begin
        r_gnt_idx <= w_sel_idx;
        r_wdata_q <= w_sel_data;
      end
      if (r_state == ST_VERIFY) begin
        r_ptr        <= r_gnt_idx;
        r_last_grant <= r_gnt_idx;
      end
    end
  end

  assign bus.req_ack    = w_ack;
  assign bus.req_err    = w_err;
  assign bus.mem_wrt_en = w_wrt_en;
  assign bus.busy       = w_busy;
  assign bus.mem_wdata  = r_wdata_q;
  assign bus.last_grant = r_last_grant;

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// Directed plus randomized bench for mem_wr_arbiter, checked against a
// transaction-level round-robin model with a behavioural memory register.
module tb_mem_wr_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mem_wr_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

  mem_wr_arbiter #(.N_REQ(N), .DW(DW)) dut (
    .in_clk (clk),
    .in_rst (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory register: captures on the write strobe, optional readback override.
  logic [DW-1:0] r_mem = '0;
  logic          ovr_en = 1'b0;
  logic [DW-1:0] ovr_val = '0;
  always @(posedge clk) if (bus.mem_wrt_en) r_mem <= bus.mem_wdata;
  assign bus.mem_rdata = ovr_en ? ovr_val : r_mem;

  int m_ptr;
  int ack_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_data  = '0;
    ovr_en        = 1'b0;
    rst_n         = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = N - 1;
  endtask

  task automatic idle_cycle();
    bus.req_valid = '0;
    @(posedge clk); @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_wren", 32'(bus.mem_wrt_en), 0);
    chk("idle_ack", 32'(bus.req_ack), 0);
  endtask

  // One full transaction; caller is at a negedge with the DUT in IDLE.
  task automatic serve(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                       input logic [N-1:0] v2, input logic [N*DW-1:0] d2,
                       input bit corrupt, input logic [DW-1:0] cval,
                       output int w);
    int ww;
    logic [DW-1:0] ed;
    logic [DW-1:0] rb;
    bus.req_valid = v;
    bus.req_data  = d;
    ww = -1;
    for (int k = 1; k <= int'(N); k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (ww < 0 && v[i]) ww = i;
    end
    ed = d[ww*DW +: DW];
    @(posedge clk); @(negedge clk);
    chk("wr_en", 32'(bus.mem_wrt_en), 1);
    chk("wr_data", 32'(bus.mem_wdata), 32'(ed));
    chk("wr_ack", 32'(bus.req_ack), 0);
    chk("wr_busy", 32'(bus.busy), 1);
    bus.req_valid = v2;
    bus.req_data  = d2;
    ovr_en  = corrupt;
    ovr_val = cval;
    @(posedge clk); @(negedge clk);
    rb = corrupt ? cval : ed;
    chk("vf_ack", 32'(bus.req_ack), 32'(1) << ww);
    chk("vf_err", 32'(bus.req_err), 32'(rb != ed));
    chk("vf_wren", 32'(bus.mem_wrt_en), 0);
    chk("vf_data", 32'(bus.mem_wdata), 32'(ed));
    chk("vf_busy", 32'(bus.busy), 1);
    ack_cyc = cyc;
    ovr_en  = 1'b0;
    m_ptr   = ww;
    @(posedge clk); @(negedge clk);
    chk("id_busy", 32'(bus.busy), 0);
    chk("id_ack", 32'(bus.req_ack), 0);
    chk("id_err", 32'(bus.req_err), 0);
    chk("last_grant", 32'(bus.last_grant), 32'(ww));
    w = ww;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int prev [N];
    logic [N-1:0]    v, v2;
    logic [N*DW-1:0] d, d2;

    // reset values
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(bus.req_ack), 0);
    chk("rst_err", 32'(bus.req_err), 0);
    chk("rst_wren", 32'(bus.mem_wrt_en), 0);
    chk("rst_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_lg", 32'(bus.last_grant), N - 1);
    rst_n = 1'b1;
    m_ptr = N - 1;

    // single request on requester 2
    d = {6'h00, 6'h2A, 6'h00, 6'h00};
    serve(4'b0100, d, 4'b0100, d, 1'b0, '0, w);
    idle_cycle();

    // simultaneous requests from reset, each drops after its ack
    do_reset();
    d = {6'h04, 6'h03, 6'h02, 6'h01};
    v = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      serve(v, d, v, d, 1'b0, '0, w);
      v[w] = 1'b0;
    end
    idle_cycle();

    // fairness between requesters 0 and 3
    for (int k = 0; k < int'(N); k++) prev[k] = -1;
    d = {6'h33, 6'h00, 6'h00, 6'h11};
    for (int k = 0; k < 4; k++) begin
      serve(4'b1001, d, 4'b1001, d, 1'b0, '0, w);
      if (prev[w] >= 0) chk("fair_gap", 32'((ack_cyc - prev[w]) <= 6), 1);
      prev[w] = ack_cyc;
    end
    idle_cycle();

    // readback error, then a clean transaction
    d = {6'h00, 6'h00, 6'h3F, 6'h00};
    serve(4'b0010, d, 4'b0010, d, 1'b1, 6'h00, w);
    serve(4'b0010, d, 4'b0010, d, 1'b0, 6'h00, w);
    idle_cycle();

    // withdrawal after capture with changed data
    d  = {6'h00, 6'h00, 6'h15, 6'h00};
    d2 = {6'h00, 6'h00, 6'h2B, 6'h00};
    serve(4'b0010, d, 4'b0000, d2, 1'b0, '0, w);
    chk("wd_mem", 32'(r_mem), 32'h15);
    idle_cycle();

    // reset during WRITE
    bus.req_valid = 4'b1111;
    bus.req_data  = 24'($urandom);
    @(posedge clk); @(negedge clk);
    chk("mr_wren", 32'(bus.mem_wrt_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_wren0", 32'(bus.mem_wrt_en), 0);
    chk("mr_busy0", 32'(bus.busy), 0);
    chk("mr_ack0", 32'(bus.req_ack), 0);
    chk("mr_wdata0", 32'(bus.mem_wdata), 0);
    chk("mr_lg", 32'(bus.last_grant), N - 1);
    @(posedge clk); @(negedge clk);
    chk("mr_noack", 32'(bus.req_ack), 0);
    rst_n = 1'b1;
    m_ptr = N - 1;
    d = 24'($urandom);
    serve(4'b1111, d, 4'b1111, d, 1'b0, '0, w);

    // randomized traffic
    for (int k = 0; k < 30; k++) begin
      v  = N'($urandom_range(0, 15));
      d  = 24'($urandom);
      v2 = N'($urandom);
      d2 = 24'($urandom);
      if (v == '0) begin
        idle_cycle();
      end else begin
        serve(v, d, v2, d2, ($urandom_range(0, 3) == 0), DW'($urandom), w);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
